// File: rtl/cpu_pkg.sv
// Shared fetch-side types: FSM state encoding, queue entry layout and fetch constants.
package cpu_pkg;

  localparam int          INST_W  = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    FLUSH
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } iq_entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// Circular instruction queue with synchronous clear and a registered head entry.
module ifetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      srst,
  input  logic      clear,
  input  logic      push,
  input  iq_entry_t push_data,
  input  logic      pop,
  output logic [AW:0] count,
  output logic      valid,
  output iq_entry_t head
);

  iq_entry_t       mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  iq_entry_t       head_q, head_d;
  logic            do_push, do_pop;

  always_comb begin
    do_push  = push && !clear;
    do_pop   = pop && !clear && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
    // The head is precomputed so decode sees a flopped entry; a push into an
    // otherwise empty slot must forward the incoming word.
    head_d = '0;
    if (count_d != '0) begin
      if (do_push && (wr_ptr_q == rd_ptr_d)) head_d = push_data;
      else                                   head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign count = count_q;
  assign valid = (count_q != '0);
  assign head  = head_q;

endmodule

// File: rtl/ifetch_unit.sv
// Fetch front end: owns the PC, issues one icache request at a time and queues words for decode.
// Optional macro IFQ_BYPASS_EN forwards a response straight to decode when the queue is empty.
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          IQ_DEPTH = 4,
  parameter int          IQ_AW    = $clog2(IQ_DEPTH)
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_rreq,
  output logic [31:0] inst_addr,
  output logic        branch_flush,
  output logic        pause_icache,
  input  logic        icache_stall,
  input  logic        inst_valid,
  input  logic [31:0] inst_out,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  input  logic        id_ready
);

  localparam logic [IQ_AW+1:0] DEPTH_W = (IQ_AW+2)'(IQ_DEPTH);

  fetch_state_t       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        inst_addr_q, inst_addr_d;
  logic               inst_rreq_q, branch_flush_q;
  logic [IQ_AW:0]     iq_count;
  logic               iq_valid;
  iq_entry_t          iq_head, push_entry;
  logic               push_en, pop_en, bypass, outstanding;
  logic [IQ_AW+1:0]   occupancy, count_after;
  logic [2:0]         unused_in;

  // Stall is informational only; the low PC bits are always forced to zero.
  assign unused_in = {icache_stall, redirect_pc[1:0]};

  always_comb begin
    outstanding = (state_q == REQ) || (state_q == WAIT);
    occupancy   = {1'b0, iq_count} + {{(IQ_AW+1){1'b0}}, outstanding};
    pop_en      = iq_valid && id_ready && !redirect_valid;
    push_entry  = '{pc: pc_q, inst: inst_out};
    state_d     = state_q;
    pc_d        = pc_q;
    inst_addr_d = inst_addr_q;
    push_en     = 1'b0;
    bypass      = 1'b0;
    count_after = {1'b0, iq_count};
    case (state_q)
      IDLE:  if (occupancy < DEPTH_W) state_d = REQ;
      REQ:   state_d = WAIT;
      WAIT: begin
        if (inst_valid) begin
`ifdef IFQ_BYPASS_EN
          bypass = (iq_count == '0) && id_ready;
`endif
          push_en     = !bypass;
          count_after = {1'b0, iq_count} + {{(IQ_AW+1){1'b0}}, push_en}
                        - {{(IQ_AW+1){1'b0}}, pop_en};
          pc_d        = pc_q + PC_STEP;
          // Re-request only if the next response is guaranteed a slot.
          state_d     = (count_after < DEPTH_W) ? REQ : IDLE;
        end
      end
      FLUSH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (redirect_valid) begin
      push_en = 1'b0;
      bypass  = 1'b0;
      pc_d    = {redirect_pc[31:2], 2'b00};
      state_d = (state_q == IDLE) ? IDLE : FLUSH;
    end
    if (state_d == REQ) inst_addr_d = pc_d;
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q        <= IDLE;
      pc_q           <= RESET_PC;
      inst_addr_q    <= RESET_PC;
      inst_rreq_q    <= 1'b0;
      branch_flush_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      inst_addr_q    <= inst_addr_d;
      inst_rreq_q    <= (state_d == REQ);
      branch_flush_q <= (state_d == FLUSH);
    end
  end

  ifetch_queue #(
    .DEPTH (IQ_DEPTH),
    .AW    (IQ_AW)
  ) u_queue (
    .clk       (cpu_clk),
    .srst      (cpu_rst),
    .clear     (redirect_valid),
    .push      (push_en),
    .push_data (push_entry),
    .pop       (pop_en),
    .count     (iq_count),
    .valid     (iq_valid),
    .head      (iq_head)
  );

  assign inst_rreq    = inst_rreq_q;
  assign inst_addr    = inst_addr_q;
  assign branch_flush = branch_flush_q;
  assign pause_icache = 1'b0;

`ifdef IFQ_BYPASS_EN
  assign id_valid = iq_valid || bypass;
  assign id_pc    = bypass ? pc_q : iq_head.pc;
  assign id_inst  = bypass ? inst_out : iq_head.inst;
`else
  assign id_valid = iq_valid;
  assign id_pc    = iq_head.pc;
  assign id_inst  = iq_head.inst;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a 1-cycle-hit icache model and an in-order decode scoreboard.
module tb_ifetch_unit;
  import cpu_pkg::*;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam int          DEPTH  = 4;
`ifdef IFQ_BYPASS_EN
  localparam int REQ_TO_VALID = 1;
`else
  localparam int REQ_TO_VALID = 2;
`endif

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_rreq, branch_flush, pause_icache;
  logic [31:0] inst_addr;
  logic        icache_stall = 1'b0;
  logic        inst_valid = 1'b0;
  logic [31:0] inst_out = '0;
  logic        id_valid;
  logic [31:0] id_pc, id_inst;
  logic        id_ready = 1'b1;

  int          checks = 0;
  int          errors = 0;
  int          req_cnt = 0;
  int          pend = 0;
  int          stall_cycles = 0;
  int          cyc = 0;
  int          first_req_cyc = -1;
  int          first_vld_cyc = -1;
  int          base = 0;
  bit          awaiting = 1'b0;
  logic [31:0] exp_fetch = RST_PC;
  iq_entry_t   exp_q[$];
  iq_entry_t   mon_e;

  always #5 cpu_clk = ~cpu_clk;

  ifetch_unit dut (
    .cpu_clk        (cpu_clk),
    .cpu_rst        (cpu_rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_rreq      (inst_rreq),
    .inst_addr      (inst_addr),
    .branch_flush   (branch_flush),
    .pause_icache   (pause_icache),
    .icache_stall   (icache_stall),
    .inst_valid     (inst_valid),
    .inst_out       (inst_out),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_inst        (id_inst),
    .id_ready       (id_ready)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int start;
    start = req_cnt;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (req_cnt != start) return;
    end
    checks++;
    errors++;
    $error("FAIL %s: no request within 40 cycles, got 0 expected 1", tag);
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  // Icache model: answers each request after 1 + stall_cycles cycles.
  initial begin
    forever begin
      tick();
      inst_valid   = 1'b0;
      icache_stall = 1'b0;
      if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) begin
          inst_valid = 1'b1;
          inst_out   = word_of(exp_fetch);
        end else begin
          icache_stall = 1'b1;
        end
      end
    end
  end

  // Monitor and scoreboard, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge cpu_clk);
      cyc++;
      if (cpu_rst) begin
        exp_q.delete();
        exp_fetch     = RST_PC;
        pend          = 0;
        awaiting      = 1'b0;
        first_req_cyc = -1;
        first_vld_cyc = -1;
      end else begin
`ifndef IFQ_BYPASS_EN
        chk1("id_valid_vs_queue", id_valid, exp_q.size() != 0);
`endif
        if (inst_rreq === 1'b1) begin
          chk("req_addr", inst_addr, exp_fetch);
          chk1("req_credit", inst_rreq, exp_q.size() < DEPTH);
          req_cnt++;
          pend     = 1 + stall_cycles;
          awaiting = 1'b1;
          if (first_req_cyc < 0) first_req_cyc = cyc;
        end
        if (id_valid === 1'b1 && first_req_cyc >= 0 && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (redirect_valid) begin
          exp_q.delete();
          exp_fetch = {redirect_pc[31:2], 2'b00};
          awaiting  = 1'b0;
          pend      = 0;
        end else begin
          if (inst_valid && awaiting) begin
            exp_q.push_back('{pc: exp_fetch, inst: word_of(exp_fetch)});
            exp_fetch = exp_fetch + 32'd4;
            awaiting  = 1'b0;
          end
          if (id_valid === 1'b1 && id_ready) begin
            chk1("pop_nonempty", 1'b1, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
              mon_e = exp_q.pop_front();
              $display("pop pc=%h inst=%h", id_pc, id_inst);
              chk("id_pc", id_pc, mon_e.pc);
              chk("id_inst", id_inst, mon_e.inst);
            end
          end
        end
      end
    end
  end

  initial begin
    repeat (3) tick();
    chk1("rst_rreq", inst_rreq, 1'b0);
    chk("rst_addr", inst_addr, RST_PC);
    chk1("rst_flush", branch_flush, 1'b0);
    chk1("rst_pause", pause_icache, 1'b0);
    chk1("rst_idv", id_valid, 1'b0);
    chk("rst_idpc", id_pc, 32'h0);
    chk("rst_idinst", id_inst, 32'h0);
    cpu_rst = 1'b0;

    // Sequential fetch with hits and decode always ready.
    for (int i = 0; i < 3; i++) begin
      wait_req("seq_req");
      chk("seq_addr", inst_addr, RST_PC + 32'(4 * i));
    end
    repeat (4) tick();
    chk("latency", 32'(first_vld_cyc - first_req_cyc), 32'(REQ_TO_VALID));

    // Long refill cycles.
    stall_cycles = 3;
    wait_req("stall_req0");
    wait_req("stall_req1");
    stall_cycles = 0;
    repeat (10) tick();

    // Decode blocked: queue fills to depth and fetching stops.
    id_ready = 1'b0;
    redirect_to(32'h0000_1000);
    base = req_cnt;
    repeat (20) tick();
    chk("fill_reqs", 32'(req_cnt - base), 32'd4);
    chk1("fill_rreq", inst_rreq, 1'b0);
    chk1("fill_idv", id_valid, 1'b1);
    chk("fill_head", id_pc, 32'h0000_1000);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    base = req_cnt;
    repeat (10) tick();
    chk("pulse_reqs", 32'(req_cnt - base), 32'd1);

    // Redirect while idle: no flush pulse.
    redirect_to(32'h0000_6000);
    chk1("idle_redir_flush", branch_flush, 1'b0);
    chk1("idle_redir_idv", id_valid, 1'b0);

    // Redirect while waiting on a hit: stale word dropped, flush pulse.
    id_ready = 1'b1;
    repeat (12) tick();
    wait_req("pre_redir_req");
    redirect_to(32'h0040_0013);
    chk1("flush_pulse", branch_flush, 1'b1);
    chk1("flush_idv", id_valid, 1'b0);
    chk1("flush_rreq", inst_rreq, 1'b0);
    tick();
    chk1("flush_end", branch_flush, 1'b0);
    wait_req("redir_req");
    chk("redir_addr", inst_addr, 32'h0040_0010);
    repeat (6) tick();

    // Redirect coincident with a response while two entries are queued.
    id_ready = 1'b0;
    redirect_to(32'h0000_2000);
    for (int i = 0; i < 3; i++) wait_req("two_req");
    chk1("two_idv", id_valid, 1'b1);
    redirect_to(32'h0000_3000);
    chk1("drop_idv", id_valid, 1'b0);
    id_ready = 1'b1;
    wait_req("after_drop_req");
    chk("after_drop_addr", inst_addr, 32'h0000_3000);
    repeat (6) tick();

    // PC wrap at the top of the address space.
    redirect_to(32'hFFFF_FFFC);
    wait_req("wrap_req0");
    chk("wrap_first", inst_addr, 32'hFFFF_FFFC);
    wait_req("wrap_req1");
    chk("wrap_addr", inst_addr, 32'h0000_0000);
    repeat (4) tick();

    // Reset mid-wait with three queued entries.
    id_ready = 1'b0;
    redirect_to(32'h0000_5000);
    for (int i = 0; i < 4; i++) wait_req("three_req");
    chk1("three_idv", id_valid, 1'b1);
    cpu_rst = 1'b1;
    tick();
    cpu_rst = 1'b0;
    chk1("mid_rst_rreq", inst_rreq, 1'b0);
    chk("mid_rst_addr", inst_addr, RST_PC);
    chk1("mid_rst_flush", branch_flush, 1'b0);
    chk1("mid_rst_idv", id_valid, 1'b0);
    chk("mid_rst_idpc", id_pc, 32'h0);
    chk("mid_rst_idinst", id_inst, 32'h0);
    wait_req("post_rst_req");
    chk("post_rst_addr", inst_addr, RST_PC);
    id_ready = 1'b1;
    repeat (8) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
